// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry controller: scan FSM states, special key
// codes and the (row, col) to key-code mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    localparam logic [3:0] CODE_STAR = 4'hA;
    localparam logic [3:0] CODE_HASH = 4'hB;

    // The 4x3 telephone layout gets its printed legends; any other geometry is linear.
    function automatic logic [3:0] key_code_of(input int rows, input int cols,
                                               input int r, input int c);
        logic [3:0] code;
        if (rows == 4 && cols == 3) begin
            if (r < 3)       code = 4'(r * 3 + c + 1);
            else if (c == 0) code = CODE_STAR;
            else if (c == 1) code = 4'h0;
            else             code = CODE_HASH;
        end else begin
            code = 4'(r * cols + c);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce_timer.sv
// Stable-cycle counter shared by the press and release debounce phases;
// done is raised while the count sits at DEBOUNCE_CYCLES-1.
module keypad_debounce_timer #(
    parameter int DEBOUNCE_CYCLES = 800000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)       count_d = '0;
        else if (enable_i) count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) count_q <= '0;
        else       count_q <= count_d;
    end

    assign done_o = (count_q == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Matrix keypad scanner with press/release debounce, digit shift chain and
// sticky game-start flag. Define KEYPAD_STAR_CLEAR_EN to make '*' clear the digits.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int         ROWS            = 4,
    parameter int         COLS            = 3,
    parameter int         DEBOUNCE_CYCLES = 800000,
    parameter int         DIGITS          = 2,
    parameter logic [3:0] START_CODE      = 4'hB
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [COLS-1:0]              keyboard_cols,
    output logic [ROWS-1:0]              keyboard_rows,
    output logic                         key_valid,
    output logic [3:0]                   key_code,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         start_game
);
    localparam int RW  = $clog2(ROWS);
    localparam int CIW = $clog2(COLS);
    localparam int DCW = $clog2(DIGITS + 1);

    kp_state_e             state_q, state_d;
    logic [ROWS-1:0]       rows_q, rows_d;
    logic [COLS-1:0]       pat_q, pat_d;
    logic [RW-1:0]         row_idx_q, row_idx_d;
    logic [CIW-1:0]        col_idx_q, col_idx_d;
    logic                  key_valid_q, key_valid_d;
    logic [3:0]            key_code_q, key_code_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [DCW-1:0]        count_q, count_d;
    logic                  start_q, start_d;

    logic                  tmr_clr, tmr_en, tmr_done;
    logic                  cols_onehot;
    logic [RW-1:0]         row_enc;
    logic [CIW-1:0]        col_enc;
    logic [3:0]            new_code;

    keypad_debounce_timer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clear_i  (tmr_clr),
        .enable_i (tmr_en),
        .done_o   (tmr_done)
    );

    assign cols_onehot = (keyboard_cols != '0) &&
                         ((keyboard_cols & (keyboard_cols - COLS'(1))) == '0);
    assign new_code    = key_code_of(ROWS, COLS, int'(row_idx_q), int'(col_idx_q));

    always_comb begin
        row_enc = '0;
        for (int i = 0; i < ROWS; i++) if (rows_q[i]) row_enc = RW'(i);
        col_enc = '0;
        for (int i = 0; i < COLS; i++) if (keyboard_cols[i]) col_enc = CIW'(i);
    end

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        pat_d       = pat_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digits_d    = digits_q;
        count_d     = count_q;
        start_d     = start_q;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;

        case (state_q)
            SCAN: begin
                // Once the game has started the scanner parks and ignores all keys.
                if (!start_q) begin
                    if (cols_onehot) begin
                        pat_d     = keyboard_cols;
                        row_idx_d = row_enc;
                        col_idx_d = col_enc;
                        state_d   = DEB_PRESS;
                    end else begin
                        rows_d = {rows_q[ROWS-2:0], rows_q[ROWS-1]};
                    end
                end
            end
            DEB_PRESS: begin
                if (keyboard_cols != pat_q) begin
                    state_d = SCAN;
                end else if (tmr_done) begin
                    state_d     = HELD;
                    key_valid_d = 1'b1;
                    key_code_d  = new_code;
                    if (new_code == START_CODE) begin
                        start_d = 1'b1;
`ifdef KEYPAD_STAR_CLEAR_EN
                    end else if (new_code == CODE_STAR) begin
                        digits_d = '0;
                        count_d  = '0;
`endif
                    end else begin
                        digits_d = (digits_q << 4) | (4*DIGITS)'(new_code);
                        count_d  = (count_q == DCW'(DIGITS)) ? DCW'(1) : count_q + DCW'(1);
                    end
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            HELD: begin
                if (keyboard_cols == '0) state_d = DEB_REL;
            end
            DEB_REL: begin
                if (keyboard_cols != '0) begin
                    state_d = HELD;
                end else if (tmr_done) begin
                    state_d = SCAN;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SCAN;
            rows_q      <= ROWS'(1);
            pat_q       <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            digits_q    <= '0;
            count_q     <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            pat_q       <= pat_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            start_q     <= start_d;
        end
    end

    assign keyboard_rows = rows_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign digits        = digits_q;
    assign digit_count   = count_q;
    assign start_game    = start_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: emulates a physical keypad matrix and compares
// every cycle against a behavioural model of scanning, debounce and digit entry.
module tb_keypad_entry_ctrl;
    localparam int ROWS   = 4;
    localparam int COLS   = 3;
    localparam int DEB    = 8;
    localparam int DIGITS = 2;
    localparam int DCW    = $clog2(DIGITS + 1);

    localparam int PH_SCAN  = 0;
    localparam int PH_PRESS = 1;
    localparam int PH_HELD  = 2;
    localparam int PH_REL   = 3;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [COLS-1:0]     keyboard_cols = '0;
    logic [ROWS-1:0]     keyboard_rows;
    logic                key_valid;
    logic [3:0]          key_code;
    logic [4*DIGITS-1:0] digits;
    logic [DCW-1:0]      digit_count;
    logic                start_game;

    keypad_entry_ctrl #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .DEBOUNCE_CYCLES (DEB),
        .DIGITS          (DIGITS),
        .START_CODE      (4'hB)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .keyboard_cols (keyboard_cols),
        .keyboard_rows (keyboard_rows),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digits        (digits),
        .digit_count   (digit_count),
        .start_game    (start_game)
    );

    always #5 clk = ~clk;

    // Keypad emulation: which row the pressed keys sit on and which columns they pull.
    int              pr      = 0;
    logic [COLS-1:0] pcols   = '0;
    logic            pressed = 1'b0;
    logic            glitch  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;

    // Behavioural model state.
    int         keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int         m_phase, m_row, m_run, m_r, m_c, m_cnt;
    logic [COLS-1:0] m_pat;
    logic       m_valid, m_start;
    logic [3:0] m_code;
    int         m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = PH_SCAN;
        m_row   = 0;
        m_run   = 0;
        m_r     = 0;
        m_c     = 0;
        m_cnt   = 0;
        m_pat   = '0;
        m_valid = 1'b0;
        m_start = 1'b0;
        m_code  = 4'h0;
        m_hist.delete();
    endtask

    function automatic logic [4*DIGITS-1:0] model_digits();
        logic [4*DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < m_hist.size(); i++) v[4*i +: 4] = 4'(m_hist[i]);
        return v;
    endfunction

    task automatic model_accept();
        int code;
        code    = keymap[m_r * COLS + m_c];
        m_valid = 1'b1;
        m_code  = 4'(code);
        if (code == 11) begin
            m_start = 1'b1;
`ifdef KEYPAD_STAR_CLEAR_EN
        end else if (code == 10) begin
            m_hist.delete();
            m_cnt = 0;
`endif
        end else begin
            m_hist.push_front(code);
            if (m_hist.size() > DIGITS) void'(m_hist.pop_back());
            m_cnt = (m_cnt == DIGITS) ? 1 : m_cnt + 1;
        end
    endtask

    // Predicts outputs after the next rising edge, given the columns presented to it.
    task automatic model_step(input logic [COLS-1:0] c);
        m_valid = 1'b0;
        case (m_phase)
            PH_SCAN: begin
                if (!m_start) begin
                    if ($countones(c) == 1) begin
                        m_pat   = c;
                        m_r     = m_row;
                        m_c     = $clog2(c);
                        m_run   = 0;
                        m_phase = PH_PRESS;
                    end else begin
                        m_row = (m_row + 1) % ROWS;
                    end
                end
            end
            PH_PRESS: begin
                if (c != m_pat) m_phase = PH_SCAN;
                else begin
                    m_run++;
                    if (m_run == DEB) begin
                        model_accept();
                        m_phase = PH_HELD;
                    end
                end
            end
            PH_HELD: begin
                if (c == '0) begin
                    m_run   = 0;
                    m_phase = PH_REL;
                end
            end
            default: begin
                if (c != '0) m_phase = PH_HELD;
                else begin
                    m_run++;
                    if (m_run == DEB) m_phase = PH_SCAN;
                end
            end
        endcase
    endtask

    // Per-cycle compare, then drive the columns the keypad would present.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #3;
            check("rows", keyboard_rows, 32'(1 << m_row));
            check("key_valid", key_valid, m_valid);
            check("key_code", key_code, m_code);
            check("digits", digits, model_digits());
            check("digit_count", digit_count, m_cnt);
            check("start_game", start_game, m_start);
            if (key_valid) n_valid++;
            keyboard_cols = (pressed && !glitch && keyboard_rows[pr]) ? pcols : '0;
            if (!rstn) model_reset();
            else       model_step(keyboard_cols);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn    = 1'b0;
        pressed = 1'b0;
        glitch  = 1'b0;
        model_reset();
        cycles(2);
        #2;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic tap(input int r, input logic [COLS-1:0] cm, input int hold, input int rel);
        pr      = r;
        pcols   = cm;
        pressed = 1'b1;
        cycles(hold);
        pressed = 1'b0;
        cycles(rel);
    endtask

    logic [ROWS-1:0] rows_seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                      4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int mode, r, c;
        logic [COLS-1:0] multi [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

        // Idle scan after reset.
        cycles(2);
        #2;
        rstn = 1'b1;
        #1;
        check("idle_rows0", keyboard_rows, 4'b0001);
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #4;
            check("idle_rows_seq", keyboard_rows, rows_seq[i]);
        end
        check("idle_no_valid", n_valid, 0);

        // Single key '5', held 20 cycles.
        n_valid = 0;
        tap(1, 3'b010, 20, 14);
        check("k5_pulses", n_valid, 1);
        check("k5_code", key_code, 4'h5);
        check("k5_digits", digits, 8'h05);
        check("k5_count", digit_count, 1);

        // Sequence 3, 7, 9 from a fresh reset.
        do_reset();
        n_valid = 0;
        tap(0, 3'b100, 16, 12);
        check("k3_count", digit_count, 1);
        tap(2, 3'b001, 16, 12);
        check("k7_count", digit_count, 2);
        tap(2, 3'b100, 16, 12);
        check("k9_count", digit_count, 1);
        check("k379_digits", digits, 8'h79);
        check("k379_pulses", n_valid, 3);

        // '1' with a bounce early in the press debounce.
        n_valid = 0;
        pr = 0;
        pcols = 3'b001;
        pressed = 1'b1;
        cycles(4);
        glitch = 1'b1;
        cycles(1);
        glitch = 1'b0;
        check("bounce_no_event", n_valid, 0);
        cycles(16);
        pressed = 1'b0;
        cycles(12);
        check("bounce_pulses", n_valid, 1);
        check("bounce_code", key_code, 4'h1);
        check("bounce_digits", digits, 8'h91);

        // Randomised keys, hold/release lengths, bounces and multi-column presses.
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 3);
            r    = $urandom_range(0, ROWS - 1);
            c    = $urandom_range(0, COLS - 1);
            if (r == 3 && c == 2) c = 1;
            case (mode)
                0: tap(r, COLS'(1 << c), $urandom_range(6, 22), $urandom_range(9, 16));
                1: begin
                    pr = r; pcols = COLS'(1 << c); pressed = 1'b1;
                    cycles($urandom_range(2, 8));
                    glitch = 1'b1;
                    cycles($urandom_range(1, 2));
                    glitch = 1'b0;
                    cycles($urandom_range(8, 18));
                    pressed = 1'b0;
                    cycles(12);
                end
                2: begin
                    tap(r, COLS'(1 << c), 16, $urandom_range(2, 6));
                    tap(r, COLS'(1 << c), $urandom_range(3, 8), 12);
                end
                default: tap(r, multi[$urandom_range(0, 3)], $urandom_range(6, 12), 4);
            endcase
        end

        // Reset asserted in the middle of a press debounce.
        pr = 2;
        pcols = 3'b001;
        pressed = 1'b1;
        cycles(6);
        #2;
        rstn = 1'b0;
        pressed = 1'b0;
        model_reset();
        #1;
        check("rst_rows", keyboard_rows, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_digits", digits, 0);
        check("rst_count", digit_count, 0);
        check("rst_start", start_game, 0);
        cycles(2);
        #2;
        rstn = 1'b1;
        n_valid = 0;
        cycles(20);
        check("rst_no_valid", n_valid, 0);

        // '5' then '#' starts the game and freezes the scanner.
        tap(1, 3'b010, 20, 14);
        n_valid = 0;
        tap(3, 3'b100, 20, 14);
        check("hash_pulses", n_valid, 1);
        check("hash_code", key_code, 4'hB);
        check("hash_start", start_game, 1);
        check("hash_digits", digits, 8'h05);
        check("hash_rows", keyboard_rows, 4'b1000);
        n_valid = 0;
        tap(0, 3'b001, 20, 14);
        check("frozen_no_valid", n_valid, 0);
        check("frozen_rows", keyboard_rows, 4'b1000);
        check("frozen_digits", digits, 8'h05);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Parametrised matrix-keypad scanner with a per-key debounce FSM, a configurable-depth digit shift chain and game-start detection.
- Drives the keypad rows and samples the columns; emits debounced key events and the last DIGITS digits entered.
- Sits between the board keypad pins and the game/bingo control logic.

Parameters:
ROWS, 4, number of keypad rows (one-hot driven); 2..8
COLS, 3, number of keypad columns (sampled); 2..8; ROWS*COLS <= 16
DEBOUNCE_CYCLES, 800000, consecutive stable cycles required on press and on release
DIGITS, 2, depth of the digit shift chain (4 bits per digit); >= 1
START_CODE, 4'hB, key code that starts the game

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
keyboard_cols  in  COLS  column sense lines, active-high, already synchronised
keyboard_rows  out  ROWS  one-hot row drive
key_valid  out  1  one-cycle pulse on each accepted key
key_code  out  4  code of the last accepted key
digits  out  4*DIGITS  digit chain; [3:0] newest, [4*DIGITS-1:4*DIGITS-4] oldest
digit_count  out  $clog2(DIGITS+1)  digits entered in the current cycle of entry
start_game  out  1  sticky flag, set by START_CODE

Behaviour:
- Reset (async, rstn low): keyboard_rows=1 (row 0), state SCAN, key_valid=0, key_code=0, digits=0, digit_count=0, start_game=0, debounce count=0.
- Key code map (ROWS=4, COLS=3): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = A(*),0,B(#). Any other geometry uses code = r*COLS+c.
- SCAN:
  - keyboard_rows rotates left by one each cycle (row ROWS-1 wraps to row 0) while keyboard_cols==0 and start_game==0.
  - If keyboard_cols is exactly one-hot, rows freeze, the row/col index is latched, the counter clears, and the FSM goes to DEB_PRESS.
  - Multiple active columns (not one-hot) are ignored; scanning continues.
- DEB_PRESS: counter increments each cycle while keyboard_cols equals the latched pattern. Any mismatch returns to SCAN (rows resume rotating next cycle). When the counter reaches DEBOUNCE_CYCLES-1, the FSM goes to HELD.
- Entering HELD (same edge):
  - key_valid=1 for exactly one cycle; key_code updates.
  - If code==START_CODE: start_game is set; digits and digit_count are unchanged.
  - Otherwise: digits shift left by 4 with the new code at [3:0], and digit_count becomes 1 if it was DIGITS, else +1.
- HELD: stays while the latched column is active. When keyboard_cols==0, the counter clears and the FSM goes to DEB_REL.
- DEB_REL: counter increments while keyboard_cols==0. Any column activity returns to HELD with no new event. At DEBOUNCE_CYCLES-1 the FSM goes to SCAN.
- Auto-repeat is not supported; a key that is held generates exactly one event.
- While start_game=1, rows freeze and no further events occur until reset.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps inside a state.

Optional Feature:
KEYPAD_STAR_CLEAR_EN
- Defined: accepted code 4'hA pulses key_valid, updates key_code, clears digits and digit_count to 0 and does not shift.
- Undefined: 4'hA is handled as an ordinary digit.

Decomposition:
- Package keypad_pkg: state enum (SCAN, DEB_PRESS, HELD, DEB_REL), CODE_STAR=4'hA, CODE_HASH=4'hB, a function mapping (row, col) to the 4-bit code.
- Sub-module keypad_debounce_timer (clear, enable, done at DEBOUNCE_CYCLES-1), instantiated once.

Test Plan (DEBOUNCE_CYCLES=8, ROWS=4, COLS=3, DIGITS=2):
- Idle after reset, cols=0 for 8 cycles -> rows go 0001,0010,0100,1000,0001,…; key_valid never asserts.
- Press r1c1 held 20 cycles, then released -> key_valid single pulse after 8 stable cycles, key_code=5, digits=8'h05, digit_count=1; no second pulse on release.
- Keys 3,7,9 with full release between -> digits=8'h79, digit_count goes 1,2,1.
- Press r0c0 with a bounce (cols=0 at cycle 4) -> no event; the FSM rescans and accepts only after 8 clean cycles.
- Press # (r3c2) -> start_game=1, digits unchanged, rows frozen; a further press of 1 produces no key_valid.
- Assert rstn low mid-DEB_PRESS -> all outputs zero immediately; rows=0001; no key_valid after release of reset.
